// File: rtl/sha3_axis_pkg.sv
// Shared types and constants for the SHA-3 AXI-Stream padder.
package sha3_axis_pkg;

    typedef enum logic [1:0] {
        MODE_224 = 2'd0,
        MODE_256 = 2'd1,
        MODE_384 = 2'd2,
        MODE_512 = 2'd3
    } sha3_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PASS     = 2'd1,
        ST_PAD      = 2'd2,
        ST_PAD_LAST = 2'd3
    } pad_state_t;

    // SHA-3 domain-separation byte and final pad bit
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    // Keccak rate expressed in 16-bit words
    function automatic logic [6:0] rate_words(input sha3_mode_t mode);
        logic [6:0] r;
        case (mode)
            MODE_224: r = 7'd72;
            MODE_256: r = 7'd68;
            MODE_384: r = 7'd52;
            default:  r = 7'd36;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha3_pad_axis.sv
// SHA-3 message padder: forwards 16-bit message words and appends the
// 0x06 ... 0x80 pad so the output is a whole number of rate blocks.
module sha3_pad_axis
    import sha3_axis_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [15:0] S_TDATA,
    input  logic [1:0]  S_TKEEP,
    input  logic [1:0]  S_TUSER,
    input  logic        S_TVALID,
    input  logic        S_TLAST,
    output logic        S_TREADY,
    output logic [15:0] M_TDATA,
    output logic [7:0]  M_TDEST,
    output logic [1:0]  M_TUSER,
    output logic        M_TID,
    output logic        M_TLAST,
    output logic        M_TVALID,
    input  logic        M_TREADY
);

    pad_state_t state;
    pad_state_t pad_next;
    sha3_mode_t mode_q;
    sha3_mode_t cur_mode;
    logic [6:0] idx_q;
    logic [6:0] idx_nxt;
    logic [6:0] rate_m1;
    logic       pend_q;
    logic       can_load;
    logic       in_accept_state;
    logic       s_fire;
    logic       at_end;
    logic       near_end;
    logic       short_last;
    logic [15:0] short_word;

    // Handshake, index and pad-word decode for the word about to be loaded
    always_comb begin
        can_load        = !M_TVALID || M_TREADY;
        in_accept_state = (state == ST_IDLE) || (state == ST_PASS);
        S_TREADY        = !ARESET && in_accept_state && can_load;
        s_fire          = S_TREADY && S_TVALID;
        cur_mode        = (state == ST_IDLE) ? sha3_mode_t'(S_TUSER) : mode_q;
        rate_m1         = rate_words(cur_mode) - 7'd1;
        at_end          = (idx_q == rate_m1);
        idx_nxt         = at_end ? '0 : idx_q + 7'd1;
        near_end        = (idx_nxt == rate_m1);
        // keep 01 has bit 0 set, so it falls through to the full-word path
        short_last      = S_TLAST && !S_TKEEP[0];
        short_word      = S_TKEEP[1] ? {S_TDATA[15:8], PAD_DOMAIN}
                                     : {PAD_DOMAIN, 8'h00};
        pad_next        = near_end ? ST_PAD_LAST : ST_PAD;
    end

    // Padding FSM with registered output word
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_224;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            M_TDATA  <= '0;
            M_TDEST  <= '0;
            M_TUSER  <= '0;
            M_TID    <= 1'b0;
            M_TLAST  <= 1'b0;
            M_TVALID <= 1'b0;
        end else if (can_load && (s_fire || state == ST_PAD || state == ST_PAD_LAST)) begin
            M_TVALID <= 1'b1;
            M_TDEST  <= {1'b0, idx_q};
            M_TUSER  <= cur_mode;
            M_TID    <= at_end;
            M_TLAST  <= 1'b0;
            idx_q    <= idx_nxt;
            case (state)
                ST_IDLE, ST_PASS: begin
                    mode_q <= cur_mode;
                    if (!S_TLAST) begin
                        M_TDATA <= S_TDATA;
                        state   <= ST_PASS;
                    end else if (short_last) begin
                        if (at_end) begin
                            M_TDATA <= short_word | {8'h00, PAD_FINAL};
                            M_TLAST <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            M_TDATA <= short_word;
                            state   <= pad_next;
                        end
                    end else begin
                        // full last word: the 0x06 goes into the following word
                        M_TDATA <= S_TDATA;
                        pend_q  <= 1'b1;
                        state   <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    pend_q <= 1'b0;
                    if (pend_q && at_end) begin
                        M_TDATA <= {PAD_DOMAIN, PAD_FINAL};
                        M_TLAST <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        M_TDATA <= pend_q ? {PAD_DOMAIN, 8'h00} : '0;
                        state   <= pad_next;
                    end
                end
                default: begin
                    M_TDATA <= {8'h00, PAD_FINAL};
                    M_TLAST <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end else if (M_TREADY) begin
            M_TVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha3_pad_axis.sv
// Self-checking bench for sha3_pad_axis against a byte-level SHA-3 pad model.
module tb_sha3_pad_axis;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [15:0] S_TDATA = '0;
    logic [1:0]  S_TKEEP = '0;
    logic [1:0]  S_TUSER = '0;
    logic        S_TVALID = 1'b0;
    logic        S_TLAST = 1'b0;
    logic        S_TREADY;
    logic [15:0] M_TDATA;
    logic [7:0]  M_TDEST;
    logic [1:0]  M_TUSER;
    logic        M_TID;
    logic        M_TLAST;
    logic        M_TVALID;
    logic        M_TREADY = 1'b0;

    sha3_pad_axis dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TUSER(S_TUSER),
        .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
        .M_TDATA(M_TDATA), .M_TDEST(M_TDEST), .M_TUSER(M_TUSER),
        .M_TID(M_TID), .M_TLAST(M_TLAST), .M_TVALID(M_TVALID),
        .M_TREADY(M_TREADY)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    logic [7:0]  msg[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_data[$];
    logic [7:0]  got_dest[$];
    logic [1:0]  got_user[$];
    logic        got_tid[$];
    logic        got_tlast[$];

    typedef struct {
        int          mode;
        int          len;
        int          ready_mode;
        bit          illegal;
        int          exp_n;
        logic [15:0] w0;
        logic [15:0] w35;
        logic [15:0] wlast;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rate in bytes: 200 - 2*digest_bytes
    function automatic int rate_bytes(input int mode);
        case (mode)
            0: return 144;
            1: return 136;
            2: return 104;
            default: return 72;
        endcase
    endfunction

    function automatic void fill_msg(input int len, input bit rnd);
        msg.delete();
        for (int i = 0; i < len; i++)
            msg.push_back(rnd ? 8'($urandom) : 8'((8'hAB + i) & 8'hFF));
    endfunction

    // SHA-3 pad: message || 0x06 || 0x00.. ; 0x80 ORed into the final byte
    function automatic void build_model(input int mode);
        logic [7:0] b[$];
        int rb;
        rb = rate_bytes(mode);
        b = msg;
        b.push_back(8'h06);
        while ((b.size() % rb) != 0) b.push_back(8'h00);
        b[b.size()-1] = b[b.size()-1] | 8'h80;
        exp_q.delete();
        for (int i = 0; i < b.size(); i += 2) exp_q.push_back({b[i], b[i+1]});
    endfunction

    task automatic send_msg(input int mode, input bit illegal, input int gap_pct);
        int nb;
        int guard;
        bit sent;
        logic [7:0] hi, lo;
        bit last;
        nb = (msg.size() == 0) ? 1 : (msg.size() + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            last = (k == nb - 1);
            hi = (2*k < msg.size()) ? msg[2*k] : 8'($urandom);
            lo = (2*k+1 < msg.size()) ? msg[2*k+1] : 8'($urandom);
            sent = 0;
            guard = 0;
            while (!sent) begin
                @(negedge ACLK);
                #1;
                S_TVALID = ($urandom_range(99) >= gap_pct);
                S_TDATA  = {hi, lo};
                S_TLAST  = last;
                S_TUSER  = (k == 0) ? 2'(mode) : 2'($urandom);
                if (!last)
                    S_TKEEP = ($urandom_range(9) == 0) ? 2'($urandom) : 2'b11;
                else if (msg.size() == 0)
                    S_TKEEP = 2'b00;
                else if (msg.size() % 2 == 1)
                    S_TKEEP = 2'b10;
                else
                    S_TKEEP = illegal ? 2'b01 : 2'b11;
                #1;
                if (S_TVALID && S_TREADY) sent = 1;
                guard++;
                if (guard > 5000) begin
                    $display("FAIL send_timeout: beat %0d never accepted, required accept", k);
                    $fatal(1, "input stalled");
                end
            end
        end
        @(negedge ACLK);
        #1;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 alternating 1,0,1,0, 2 random
    task automatic collect(input int ready_mode);
        bit done;
        int cyc;
        bit stall;
        bit phase;
        logic [15:0] pd;
        logic [7:0]  pdst;
        got_data.delete(); got_dest.delete(); got_user.delete();
        got_tid.delete(); got_tlast.delete();
        done = 0; cyc = 0; stall = 0; phase = 1; pd = '0; pdst = '0;
        while (!done && cyc < 6000) begin
            @(negedge ACLK);
            if (stall) begin
                chk("stall_valid", M_TVALID, 1);
                chk("stall_data", M_TDATA, pd);
                chk("stall_dest", M_TDEST, pdst);
            end
            case (ready_mode)
                0: M_TREADY = 1'b1;
                1: begin M_TREADY = phase; phase = ~phase; end
                default: M_TREADY = ($urandom_range(2) != 0);
            endcase
            if (M_TVALID && M_TREADY) begin
                got_data.push_back(M_TDATA);
                got_dest.push_back(M_TDEST);
                got_user.push_back(M_TUSER);
                got_tid.push_back(M_TID);
                got_tlast.push_back(M_TLAST);
                if (M_TLAST) done = 1;
            end
            stall = M_TVALID && !M_TREADY;
            pd = M_TDATA;
            pdst = M_TDEST;
            cyc++;
        end
        chk("collect_done", done, 1);
    endtask

    task automatic check_stream(input string tag, input int mode);
        int rw;
        int n;
        rw = rate_bytes(mode) / 2;
        chk({tag, "_nwords"}, got_data.size(), exp_q.size());
        n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), got_data[i], exp_q[i]);
            chk($sformatf("%s_dest[%0d]", tag, i), got_dest[i], i % rw);
            chk($sformatf("%s_user[%0d]", tag, i), got_user[i], mode);
            chk($sformatf("%s_tid[%0d]", tag, i), got_tid[i], (i % rw) == rw - 1);
            chk($sformatf("%s_tlast[%0d]", tag, i), got_tlast[i], i == exp_q.size() - 1);
        end
    endtask

    task automatic run_msg(input string tag, input int mode, input int len, input bit rnd,
                           input bit illegal, input int ready_mode, input int gap_pct);
        fill_msg(len, rnd);
        build_model(mode);
        fork
            send_msg(mode, illegal, gap_pct);
            collect(ready_mode);
        join
        check_stream(tag, mode);
    endtask

    initial begin
        tbl[0] = '{mode: 3, len: 0,   ready_mode: 0, illegal: 0, exp_n: 36, w0: 16'h0600, w35: 16'h0080, wlast: 16'h0080};
        tbl[1] = '{mode: 3, len: 1,   ready_mode: 0, illegal: 0, exp_n: 36, w0: 16'hAB06, w35: 16'h0080, wlast: 16'h0080};
        tbl[2] = '{mode: 3, len: 71,  ready_mode: 2, illegal: 0, exp_n: 36, w0: 16'hABAC, w35: 16'hF186, wlast: 16'hF186};
        tbl[3] = '{mode: 3, len: 72,  ready_mode: 0, illegal: 0, exp_n: 72, w0: 16'hABAC, w35: 16'hF1F2, wlast: 16'h0080};
        tbl[4] = '{mode: 0, len: 100, ready_mode: 1, illegal: 0, exp_n: 72, w0: 16'hABAC, w35: 16'hF1F2, wlast: 16'h0080};
        tbl[5] = '{mode: 3, len: 2,   ready_mode: 2, illegal: 1, exp_n: 36, w0: 16'hABAC, w35: 16'h0080, wlast: 16'h0080};
        tbl[6] = '{mode: 1, len: 135, ready_mode: 0, illegal: 0, exp_n: 68, w0: 16'hABAC, w35: 16'hF1F2, wlast: 16'h3186};

        // reset state
        repeat (2) @(negedge ACLK);
        chk("rst_m_tvalid", M_TVALID, 0);
        chk("rst_m_tlast", M_TLAST, 0);
        chk("rst_m_tid", M_TID, 0);
        chk("rst_s_tready", S_TREADY, 0);
        chk("rst_m_tdata", M_TDATA, 0);
        chk("rst_m_tdest", M_TDEST, 0);
        chk("rst_m_tuser", M_TUSER, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        #1;
        chk("idle_s_tready", S_TREADY, 1);

        for (int t = 0; t < 7; t++) begin
            run_msg($sformatf("vec%0d", t), tbl[t].mode, tbl[t].len, 0, tbl[t].illegal,
                    tbl[t].ready_mode, 20);
            chk($sformatf("vec%0d_n", t), got_data.size(), tbl[t].exp_n);
            if (got_data.size() == tbl[t].exp_n) begin
                chk($sformatf("vec%0d_w0", t), got_data[0], tbl[t].w0);
                chk($sformatf("vec%0d_w35", t), got_data[35], tbl[t].w35);
                chk($sformatf("vec%0d_wlast", t), got_data[tbl[t].exp_n-1], tbl[t].wlast);
            end
        end

        // reset during PAD of a mode-1 message
        fill_msg(10, 0);
        send_msg(1, 0, 0);
        M_TREADY = 1'b1;
        repeat (8) @(negedge ACLK);
        chk("pad_valid_before_rst", M_TVALID, 1);
        chk("pad_data_before_rst", M_TDATA, 16'h0000);
        #3;
        ARESET = 1'b1;
        #1;
        chk("midrst_m_tvalid", M_TVALID, 0);
        chk("midrst_m_tlast", M_TLAST, 0);
        chk("midrst_m_tid", M_TID, 0);
        chk("midrst_s_tready", S_TREADY, 0);
        chk("midrst_m_tdata", M_TDATA, 0);
        chk("midrst_m_tdest", M_TDEST, 0);
        chk("midrst_m_tuser", M_TUSER, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        run_msg("after_rst", 2, 0, 0, 0, 0, 0);
        chk("after_rst_n", got_data.size(), 52);

        // randomized messages against the pad model
        for (int r = 0; r < 12; r++) begin
            run_msg($sformatf("rnd%0d", r), $urandom_range(3), $urandom_range(300), 1,
                    1'($urandom_range(1)), $urandom_range(2), 30);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
